// File: rtl/mem_port_bridge.sv
// mem_port_bridge: registers one CPU memory request at a time, aligns sub-word
// store data and byte enables to the addressed byte lane, drives a
// request/response physical memory port and returns exactly one mem_resp pulse
// per request. A WAIT-state watchdog aborts a stalled access and sets a sticky
// bus_error flag, which is also set when a read and a write are requested together.
module mem_port_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata,
    output logic        busy,
    output logic        bus_error
);

    localparam int unsigned    CNT_W      = (TIMEOUT_CYCLES < 32'd2) ? 1 : $clog2(TIMEOUT_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic           TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_COOL  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_write_r;
    logic               accept_s;
    logic               capture_s;
    logic               timeout_s;
    logic               cnt_inc_s;

    // Byte-enable lane alignment; lanes pushed past lane 3 are discarded.
    function automatic logic [3:0] align_mask(input logic [3:0] mask, input logic [1:0] ofs);
        return mask << ofs;
    endfunction

    // Store-data lane alignment; bytes pushed past bit 31 are discarded.
    function automatic logic [31:0] align_data(input logic [31:0] data, input logic [1:0] ofs);
        return data << {ofs, 3'b000};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                // A response in the same cycle the watchdog expires still completes normally.
                if (pmem_resp) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (TIMEOUT_EN && (cnt_r == CNT_MAX)) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_inc_s   = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_COOL;
            // The CPU still holds its request during the resp cycle, so it is ignored here.
            ST_COOL: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // WAIT-cycle watchdog counter: 1 on entering WAIT, advanced each WAIT cycle without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_W'(1);
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request latch and physical-port drive; held stable from ISSUE until completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write_r       <= 1'b0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= 32'h0000_0000;
            pmem_wdata       <= 32'h0000_0000;
            pmem_byte_enable <= 4'b0000;
        end else if (accept_s) begin
            // Simultaneous read and write is resolved as a write.
            is_write_r       <= mem_write;
            pmem_read        <= ~mem_write;
            pmem_write       <= mem_write;
            pmem_address     <= {mem_address[31:2], 2'b00};
            pmem_wdata       <= mem_write ? align_data(mem_wdata, mem_address[1:0]) : 32'h0000_0000;
            pmem_byte_enable <= mem_write ? align_mask(mem_byte_enable, mem_address[1:0]) : 4'b1111;
        end else if (capture_s || timeout_s) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
        end else begin
            pmem_read        <= pmem_read;
            pmem_write       <= pmem_write;
        end
    end

    // Read-data return: captured word or error pattern; writes leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= 32'h0000_0000;
        end else if (capture_s && !is_write_r) begin
            mem_rdata <= pmem_rdata;
        end else if (timeout_s && !is_write_r) begin
            mem_rdata <= ERR_RDATA;
        end else begin
            mem_rdata <= mem_rdata;
        end
    end

    // Registered status outputs: completion pulse, busy and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_resp  <= 1'b0;
            busy      <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            mem_resp  <= (state_nxt_s == ST_RESP);
            busy      <= (state_nxt_s != ST_IDLE);
            bus_error <= bus_error | timeout_s | (accept_s && mem_read && mem_write);
        end
    end

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed self-checking bench for mem_port_bridge (watchdog shortened to 4 cycles).
module tb_mem_port_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;
    logic        busy;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;
    int resp_cnt   = 0;
    int strobe_cnt = 0;
    logic strobe_prev = 1'b0;
    int resp_snap;
    int strobe_snap;

    mem_port_bridge #(
        .TIMEOUT_CYCLES (32'd4),
        .ERR_RDATA      (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_byte_enable  (mem_byte_enable),
        .mem_resp         (mem_resp),
        .mem_rdata        (mem_rdata),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_resp        (pmem_resp),
        .pmem_rdata       (pmem_rdata),
        .busy             (busy),
        .bus_error        (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count mem_resp pulses and rising edges of the pmem strobe.
    always @(negedge clk) begin
        if (mem_resp) resp_cnt = resp_cnt + 1;
        if ((pmem_read | pmem_write) && !strobe_prev) strobe_cnt = strobe_cnt + 1;
        strobe_prev = pmem_read | pmem_write;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 32'h0; mem_wdata = 32'h0; mem_byte_enable = 4'b0000;
        pmem_resp = 1'b0; pmem_rdata = 32'h0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_resp", {31'd0, mem_resp}, 32'd0);
        check("rst_pread", {31'd0, pmem_read}, 32'd0);
        check("rst_pwrite", {31'd0, pmem_write}, 32'd0);
        check("rst_berr", {31'd0, bus_error}, 32'd0);
        check("rst_rdata", mem_rdata, 32'h0000_0000);
        check("rst_paddr", pmem_address, 32'h0000_0000);
        rst_n = 1'b1;
        tick();

        // Word read, response three cycles after the strobe rises.
        resp_snap = resp_cnt;
        mem_read = 1'b1; mem_address = 32'h0000_1004; mem_byte_enable = 4'b1111;
        tick();                                   // ISSUE
        check("rd_pread", {31'd0, pmem_read}, 32'd1);
        check("rd_pwrite", {31'd0, pmem_write}, 32'd0);
        check("rd_paddr", pmem_address, 32'h0000_1004);
        check("rd_pbe", {28'd0, pmem_byte_enable}, 32'h0000_000F);
        check("rd_busy", {31'd0, busy}, 32'd1);
        tick();                                   // WAIT cnt1
        tick();                                   // WAIT cnt2
        check("rd_wait_pread", {31'd0, pmem_read}, 32'd1);
        check("rd_wait_resp", {31'd0, mem_resp}, 32'd0);
        tick();                                   // WAIT cnt3
        pmem_resp = 1'b1; pmem_rdata = 32'hCAFE_BABE;
        tick();                                   // RESP
        pmem_resp = 1'b0; pmem_rdata = 32'h0;
        check("rd_resp", {31'd0, mem_resp}, 32'd1);
        check("rd_rdata", mem_rdata, 32'hCAFE_BABE);
        check("rd_pread_drop", {31'd0, pmem_read}, 32'd0);
        tick();                                   // COOL
        mem_read = 1'b0;
        check("rd_cool_resp", {31'd0, mem_resp}, 32'd0);
        check("rd_rdata_hold", mem_rdata, 32'hCAFE_BABE);
        tick();                                   // IDLE
        check("rd_idle_busy", {31'd0, busy}, 32'd0);
        check("rd_resp_pulses", resp_cnt - resp_snap, 32'd1);

        // Back-to-back reads with mem_read held through RESP and COOL.
        resp_snap = resp_cnt; strobe_snap = strobe_cnt;
        mem_read = 1'b1; mem_address = 32'h0000_2000;
        tick();                                   // ISSUE
        tick();                                   // WAIT
        pmem_resp = 1'b1; pmem_rdata = 32'h1111_1111;
        tick();                                   // RESP
        pmem_resp = 1'b0;
        mem_address = 32'h0000_2008;
        check("b2b_resp1", {31'd0, mem_resp}, 32'd1);
        check("b2b_rdata1", mem_rdata, 32'h1111_1111);
        check("b2b_resp_strobe", {31'd0, pmem_read}, 32'd0);
        tick();                                   // COOL
        check("b2b_cool_strobe", {31'd0, pmem_read}, 32'd0);
        check("b2b_cool_resp", {31'd0, mem_resp}, 32'd0);
        tick();                                   // IDLE
        check("b2b_idle_strobe", {31'd0, pmem_read}, 32'd0);
        tick();                                   // ISSUE (second)
        check("b2b_pread2", {31'd0, pmem_read}, 32'd1);
        check("b2b_paddr2", pmem_address, 32'h0000_2008);
        tick();                                   // WAIT
        pmem_resp = 1'b1; pmem_rdata = 32'h2222_2222;
        tick();                                   // RESP
        pmem_resp = 1'b0; mem_read = 1'b0;
        check("b2b_resp2", {31'd0, mem_resp}, 32'd1);
        check("b2b_rdata2", mem_rdata, 32'h2222_2222);
        tick(); tick();                           // COOL, IDLE
        check("b2b_strobes", strobe_cnt - strobe_snap, 32'd2);
        check("b2b_pulses", resp_cnt - resp_snap, 32'd2);

        // SB to lane 3; CPU inputs change after the latch.
        mem_write = 1'b1; mem_address = 32'h0000_3003; mem_wdata = 32'h0000_00A5; mem_byte_enable = 4'b0001;
        tick();                                   // ISSUE
        check("sb_pwrite", {31'd0, pmem_write}, 32'd1);
        check("sb_pread", {31'd0, pmem_read}, 32'd0);
        check("sb_pbe", {28'd0, pmem_byte_enable}, 32'h0000_0008);
        check("sb_pwdata", pmem_wdata, 32'hA500_0000);
        check("sb_paddr", pmem_address, 32'h0000_3000);
        mem_address = 32'h0000_0000; mem_wdata = 32'hFFFF_FFFF; mem_byte_enable = 4'b1111;
        tick();                                   // WAIT
        check("sb_wdata_stable", pmem_wdata, 32'hA500_0000);
        check("sb_addr_stable", pmem_address, 32'h0000_3000);
        pmem_resp = 1'b1; pmem_rdata = 32'hDEAD_BEEF;
        tick();                                   // RESP
        pmem_resp = 1'b0; mem_write = 1'b0;
        check("sb_resp", {31'd0, mem_resp}, 32'd1);
        check("sb_rdata_kept", mem_rdata, 32'h2222_2222);
        check("sb_strobe_drop", {31'd0, pmem_write}, 32'd0);
        tick(); tick();

        // SH to upper half.
        mem_write = 1'b1; mem_address = 32'h0000_4002; mem_wdata = 32'h0000_1234; mem_byte_enable = 4'b0011;
        tick();                                   // ISSUE
        check("sh_pbe", {28'd0, pmem_byte_enable}, 32'h0000_000C);
        check("sh_pwdata", pmem_wdata, 32'h1234_0000);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; mem_write = 1'b0;
        tick(); tick();

        // SH at offset 3: the upper byte falls off, no wrap.
        mem_write = 1'b1; mem_address = 32'h0000_4003; mem_wdata = 32'h0000_BEEF; mem_byte_enable = 4'b0011;
        tick();
        check("sh3_pbe", {28'd0, pmem_byte_enable}, 32'h0000_0008);
        check("sh3_pwdata", pmem_wdata, 32'hEF00_0000);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; mem_write = 1'b0;
        tick(); tick();
        check("pre_to_berr", {31'd0, bus_error}, 32'd0);

        // Timeout: no pmem_resp, 4 WAIT cycles then abort.
        resp_snap = resp_cnt;
        mem_read = 1'b1; mem_address = 32'h0000_5000; mem_byte_enable = 4'b1111;
        tick();                                   // ISSUE
        tick(); tick(); tick(); tick();           // WAIT cnt1..cnt4
        check("to_strobe_held", {31'd0, pmem_read}, 32'd1);
        check("to_no_resp_yet", {31'd0, mem_resp}, 32'd0);
        check("to_berr_pre", {31'd0, bus_error}, 32'd0);
        tick();                                   // RESP
        mem_read = 1'b0;
        check("to_strobe_drop", {31'd0, pmem_read}, 32'd0);
        check("to_resp", {31'd0, mem_resp}, 32'd1);
        check("to_rdata", mem_rdata, 32'h0000_0000);
        check("to_berr", {31'd0, bus_error}, 32'd1);
        tick(); tick();                           // COOL, IDLE
        check("to_berr_sticky", {31'd0, bus_error}, 32'd1);
        check("to_idle_busy", {31'd0, busy}, 32'd0);
        check("to_pulses", resp_cnt - resp_snap, 32'd1);

        // Reset in the middle of WAIT.
        resp_snap = resp_cnt;
        mem_read = 1'b1; mem_address = 32'h0000_6000;
        tick(); tick();                           // ISSUE, WAIT
        check("mr_pread_before", {31'd0, pmem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_pread_async", {31'd0, pmem_read}, 32'd0);
        check("mr_busy_async", {31'd0, busy}, 32'd0);
        check("mr_berr_clr", {31'd0, bus_error}, 32'd0);
        pmem_resp = 1'b1;
        tick(); tick();
        pmem_resp = 1'b0; mem_read = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        check("mr_no_resp", resp_cnt - resp_snap, 32'd0);
        check("mr_idle_busy", {31'd0, busy}, 32'd0);

        // Read and write together: treated as write, bus_error set.
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h0000_7001;
        mem_wdata = 32'h0000_005A; mem_byte_enable = 4'b0001;
        tick();                                   // ISSUE
        check("rw_pwrite", {31'd0, pmem_write}, 32'd1);
        check("rw_pread", {31'd0, pmem_read}, 32'd0);
        check("rw_berr", {31'd0, bus_error}, 32'd1);
        check("rw_pbe", {28'd0, pmem_byte_enable}, 32'h0000_0002);
        check("rw_pwdata", pmem_wdata, 32'h0000_5A00);
        tick();
        pmem_resp = 1'b1;
        tick();                                   // RESP
        pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        check("rw_resp", {31'd0, mem_resp}, 32'd1);
        tick(); tick();
        check("rw_berr_sticky", {31'd0, bus_error}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_bridge.md
Name: mem_port_bridge

Overview:
- Sits between the multicycle RV32I control/datapath memory port and the physical memory port.
- CPU side: level-held mem_read/mem_write with a one-cycle mem_resp, matching the control FSM's fetch2/ldr1/str1 waits.
- The block registers each request, aligns sub-word store data and byte enables to the addressed byte lane, and drives a request/response physical memory.
- It returns exactly one mem_resp per request and adds a timeout watchdog with a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles allowed before abort; 0 disables the timeout.
- ERR_RDATA, 32'h0000_0000: mem_rdata value returned on a timed-out read.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_address  in  32  CPU byte address.
- mem_wdata  in  32  CPU store data, right-justified (byte/half in low bits).
- mem_byte_enable  in  4  CPU mask, right-justified (0001 SB, 0011 SH, 1111 SW).
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  32  full aligned word read.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_address  out  32  word address {addr[31:2],2'b00}.
- pmem_wdata  out  32  lane-shifted store data.
- pmem_byte_enable  out  4  lane-shifted mask.
- pmem_resp  in  1  physical completion, may arrive any cycle after the strobe.
- pmem_rdata  in  32  valid when pmem_resp=1.
- busy  out  1  high in every state except IDLE.
- bus_error  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 (mem_rdata=0, strobes low immediately, bus_error=0); timeout counter=0.
- Reset mid-transaction aborts the transaction silently and produces no mem_resp.
- States: IDLE, ISSUE, WAIT, RESP, COOL.
- IDLE
  - Request seen (mem_read|mem_write) at edge N: latch address, the shifted data/mask (shift = addr[1:0]), and the op.
  - Go to ISSUE; pmem strobe is high from cycle N+1.
  - Shift rules: mask << addr[1:0]; data << 8*addr[1:0]; bits shifted out past bit 31/lane 3 are dropped, no wrap.
  - Read requests latch mask 1111 and data are ignored.
  - mem_read and mem_write both high: treat as write; set bus_error.
- ISSUE (one cycle): pmem_read or pmem_write asserted with latched address/data/mask. Go to WAIT; counter=1.
- WAIT
  - Strobe stays asserted and all pmem outputs stay stable.
  - pmem_resp=1: capture pmem_rdata (reads only); deassert strobe next cycle; go to RESP.
  - pmem_resp=1 in the same cycle the counter reaches TIMEOUT_CYCLES: pmem_resp wins.
  - Otherwise counter++. At counter==TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): drop strobe, set bus_error, load mem_rdata=ERR_RDATA for reads, go to RESP.
  - pmem_resp is ignored in all states except WAIT.
- RESP (one cycle): mem_resp=1. mem_rdata holds the captured word from this cycle until the next read capture; writes leave mem_rdata unchanged. Go to COOL.
- COOL (one cycle): CPU request inputs are ignored, because the FSM still holds mem_read/mem_write during its resp cycle. Go to IDLE.
- Minimum latency: request at edge N, pmem_resp in WAIT at edge N+2, mem_resp high in cycle N+3.
- A new request is accepted no earlier than edge N+5.
- bus_error clears only on reset.
- CPU inputs changing after latch have no effect on the transaction in flight.

Test Plan:
- Word read: addr 0x0000_1004, pmem_resp 3 cycles after strobe with rdata 0xCAFEBABE -> pmem_address 0x1004, one mem_resp pulse, mem_rdata=0xCAFEBABE held after.
- SB: addr 0x...0003, wdata 0x0000_00A5, mask 0001 -> pmem_byte_enable 1000, pmem_wdata 0xA500_0000.
- SH: addr 0x...0002, wdata 0x0000_1234, mask 0011 -> pmem_byte_enable 1100, pmem_wdata 0x1234_0000.
- Back-to-back: mem_read held through RESP then a new read -> exactly one pmem strobe per request, none issued during RESP/COOL, second mem_resp separate.
- Timeout: TIMEOUT_CYCLES=4, pmem_resp never asserted -> strobe dropped after 4 WAIT cycles, mem_resp pulses, mem_rdata=0, bus_error=1 sticky.
- Reset mid-WAIT, plus both read and write asserted: rst_n low in WAIT -> strobes low asynchronously, no mem_resp. After release, read+write together -> write issued, bus_error=1.
